tick_timer: RTL and testbench
=============================

# tick_timer

Programmable down-counting timer that consumes the terminal-count strobe (`tc`) of the 4-bit free-running prescaler counter and counts prescaler wraps. It expires after a programmed number of wraps, in one-shot or auto-reload mode, and raises a held interrupt with an acknowledge handshake and a sticky overrun flag. It sits directly downstream of the prescaler and feeds the interrupt/status logic.

## Interface
- `WIDTH`, default 8: width of `period` and `value`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; sampled on the `clk` rising edge.
- `tc` in 1: prescaler terminal count; a tick is a rising edge of `tc`.
- `start` in 1: arm or restart the timer (single-cycle request).
- `stop` in 1: abort the timer (single-cycle request).
- `mode` in 1: 0 = one-shot, 1 = auto-reload; sampled when `start` is accepted.
- `period` in `WIDTH`: tick count to expiry; sampled into `period_q` when `start` is accepted.
- `irq_ack` in 1: clears `irq` and `overrun`.
- `busy` out 1: high in RUN.
- `value` out `WIDTH`: remaining ticks.
- `expire` out 1: one-cycle pulse on each expiry.
- `irq` out 1: set on expiry and held until acknowledged.
- `overrun` out 1: sticky; an expiry occurred while `irq` was already pending.

## Operation
- Tick detect: `tc_q` registers `tc`. `tick = tc & ~tc_q`.
  - `tc` held high for N cycles gives exactly one tick.
  - `tc` high on the first cycle after reset counts as a tick.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start` with `period != 0`: `value <= period`, latch `period_q` and `mode_q`, go to RUN.
  - `start` with `period == 0`: ignored; stay in IDLE, no flag.
- RUN, priority stop > start > tick:
  - `stop`: `value <= 0`, go to IDLE, no expiry.
  - `start`: restart exactly as from IDLE. With `period == 0`, `start` is ignored and the timer keeps running.
  - `tick` with `value > 1`: `value <= value - 1`.
  - `tick` with `value == 1` is an expiry:
    - `mode_q = 1`: `value <= period_q`, stay in RUN.
    - `mode_q = 0`: `value <= 0`, go to DONE.
- DONE:
  - `start` restarts as from IDLE.
  - `stop`, or `irq_ack` while `irq` is high, goes to IDLE.
  - Ticks are ignored.
- `irq`: set on expiry, cleared on `irq_ack`. If both occur in the same cycle, set wins.
- `overrun`: set on expiry while `irq == 1` and `irq_ack == 0`. Cleared on `irq_ack` unless set in the same cycle.
- Arithmetic: unsigned `WIDTH` bits. The `value == 1` check precedes the decrement, so `value` never wraps below 0.
- Reset outputs: `busy` 0, `value` 0, `expire` 0, `irq` 0, `overrun` 0. Internally `tc_q` 0 and state IDLE.
- Reset during RUN or DONE aborts immediately with no expiry and no flags.

## Timing
- All outputs are registered.
- Tick latency: `tc` sampled high at edge k (with `tc_q` 0) → `value` updated after edge k.
- Expiry: `expire` and `irq` rise after the same edge that reloads or zeroes `value`. `expire` lasts exactly one cycle.
- Expiry cadence: with a free-running 4-bit prescaler, consecutive ticks are 16 cycles apart, so period P expires 16·(P−1) cycles after the first tick.
- Start to RUN: `start` at edge k → `busy` high and `value = period` after edge k.
- `irq_ack` at edge k → `irq` low after edge k, unless an expiry occurs at edge k.

## Structure
- Package `tick_timer_pkg` holds:
  - typedef `tt_state_e` (IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10);
  - constants `TT_ONESHOT = 1'b0` and `TT_AUTO = 1'b1`.
- Sub-module `tc_edge_detect` (clk, reset, in, rise): a registered rising-edge detector, reusable for other strobes.
- Top level contains the FSM, the value datapath and the flag logic.

## Test plan
- One-shot: `period = 3`, `mode = 0`, `start`, free-running prescaler.
  - `value` goes 3→2→1→0 on successive ticks; single `expire` pulse; state DONE; `irq = 1`.
  - `irq_ack` → `irq = 0`, IDLE, `busy = 0`.
- Auto-reload with overrun: `period = 2`, `mode = 1`, no ack for two expiries.
  - `value` goes 2→1→2→1→2; `irq = 1` after the first expiry; `overrun = 1` after the second.
  - `irq_ack` clears both.
- Stop collision: `stop` in the same cycle as the tick hitting `value == 1`.
  - `expire = 0`, `irq = 0`, IDLE, `value = 0`.
- Start guard: `start` with `period = 0` in IDLE → stays in IDLE, `busy = 0`, `value = 0`.
- Tick qualification: `tc` held high for 3 cycles while in RUN with `value = 5` → `value = 4` exactly once.
- Mid-run reset: `reset = 0` for one cycle during RUN with `value = 7` → all outputs 0 and IDLE on the next cycle; subsequent ticks are ignored.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick_timer block.
package tick_timer_pkg;

    // Timer control states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } tt_state_e;

    // Values of the mode input.
    localparam logic TT_ONESHOT = 1'b0;
    localparam logic TT_AUTO    = 1'b1;

endpackage : tick_timer_pkg

// File: rtl/tick_timer_if.sv
// Control/status bundle between the tick_timer and its host logic.
interface tick_timer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] period;
    logic             irq_ack;
    logic             busy;
    logic [WIDTH-1:0] value;
    logic             expire;
    logic             irq;
    logic             overrun;

    // Host side: issues commands, observes status.
    modport master (
        output start, stop, mode, period, irq_ack,
        input  busy, value, expire, irq, overrun
    );

    // Timer side: accepts commands, reports status.
    modport slave (
        input  start, stop, mode, period, irq_ack,
        output busy, value, expire, irq, overrun
    );

endinterface : tick_timer_if

// File: rtl/tc_edge_detect.sv
// Registered rising-edge detector: rise is high for the first cycle a strobe
// is seen high, however long the strobe is then held.
module tc_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic in_q;
    logic in_d;

    // Next value of the history register is simply the current input.
    always_comb begin
        in_d = in;
    end

    // History register; cleared in reset so a strobe already high on the
    // first cycle after reset still counts as an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    assign rise = in & ~in_q;

endmodule : tc_edge_detect

// File: rtl/tick_timer.sv
// Down-counting timer driven by prescaler wraps, with one-shot and
// auto-reload modes, a held interrupt and a sticky overrun flag.
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tc,
    tick_timer_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    tt_state_e        state_q,   state_d;
    logic [WIDTH-1:0] value_q,   value_d;
    logic [WIDTH-1:0] period_q,  period_d;
    logic             mode_q,    mode_d;
    logic             busy_q,    busy_d;
    logic             expire_q,  expire_d;
    logic             irq_q,     irq_d;
    logic             overrun_q, overrun_d;

    logic tick;
    logic start_ok;
    logic expiry;

    tc_edge_detect u_tc_edge (
        .clk   (clk),
        .reset (reset),
        .in    (tc),
        .rise  (tick)
    );

    // Next-state, value datapath and flag logic.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_d   = state_q;
        value_d   = value_q;
        period_d  = period_q;
        mode_d    = mode_q;
        expiry    = 1'b0;
        start_ok  = bus.start && (bus.period != '0);

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    value_d  = bus.period;
                    period_d = bus.period;
                    mode_d   = bus.mode;
                    state_d  = RUN;
                end
            end

            RUN: begin
                // stop beats start beats tick; a zero-period start is
                // ignored and the count carries on.
                if (bus.stop) begin
                    value_d = '0;
                    state_d = IDLE;
                end else if (start_ok) begin
                    value_d  = bus.period;
                    period_d = bus.period;
                    mode_d   = bus.mode;
                end else if (tick) begin
                    // Test for 1 before decrementing so value never wraps.
                    if (value_q == ONE) begin
                        expiry = 1'b1;
                        if (mode_q == TT_AUTO) begin
                            value_d = period_q;
                        end else begin
                            value_d = '0;
                            state_d = DONE;
                        end
                    end else begin
                        value_d = value_q - ONE;
                    end
                end
            end

            DONE: begin
                // Ticks are ignored while waiting for software.
                if (bus.stop) begin
                    value_d = '0;
                    state_d = IDLE;
                end else if (start_ok) begin
                    value_d  = bus.period;
                    period_d = bus.period;
                    mode_d   = bus.mode;
                    state_d  = RUN;
                end else if (bus.irq_ack && irq_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                value_d = '0;
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d == RUN);
        expire_d  = expiry;
        // A new expiry wins over a simultaneous acknowledge.
        irq_d     = expiry | (irq_q & ~bus.irq_ack);
        overrun_d = (expiry & irq_q & ~bus.irq_ack) | (overrun_q & ~bus.irq_ack);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (!reset) begin
            state_q   <= IDLE;
            value_q   <= '0;
            period_q  <= '0;
            mode_q    <= TT_ONESHOT;
            busy_q    <= 1'b0;
            expire_q  <= 1'b0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            period_q  <= period_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            expire_q  <= expire_d;
            irq_q     <= irq_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.value   = value_q;
    assign bus.expire  = expire_q;
    assign bus.irq     = irq_q;
    assign bus.overrun = overrun_q;

endmodule : tick_timer

// File: tb/tb_tick_timer.sv
// Directed self-checking bench for tick_timer.
module tb_tick_timer;
    import tick_timer_pkg::*;

    logic clk;
    logic reset;
    logic tc;

    logic       pre_en;
    logic [3:0] pre_cnt;

    int n_cmp;
    int n_mis;
    int n_exp;

    tick_timer_if #(.WIDTH(8)) tif ();

    tick_timer #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .tc    (tc),
        .bus   (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge. When enabled, a 4-bit prescaler model drives tc.
    task automatic step();
        @(posedge clk);
        #1;
        if (pre_en) begin
            pre_cnt = pre_cnt + 4'd1;
            tc      = (pre_cnt == 4'hF);
        end
    endtask

    // One isolated tick: tc low for a cycle, then high for exactly one edge.
    task automatic tick_once();
        tc = 1'b0;
        step();
        tc = 1'b1;
        step();
        tc = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] p, input logic m);
        tif.period = p;
        tif.mode   = m;
        tif.start  = 1'b1;
        step();
        tif.start  = 1'b0;
    endtask

    // Step until value changes or the budget runs out; counts expire pulses.
    task automatic wait_value_change(input int budget, output int steps);
        logic [7:0] prev;
        prev  = tif.value;
        steps = 0;
        while (steps < budget) begin
            step();
            steps++;
            if (tif.expire === 1'b1) n_exp++;
            if (tif.value !== prev) break;
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        tc          = 1'b0;
        tif.start   = 1'b0;
        tif.stop    = 1'b0;
        tif.mode    = 1'b0;
        tif.period  = 8'd0;
        tif.irq_ack = 1'b0;
        step();
        step();
        n_cmp++; if ({tif.busy, tif.expire, tif.irq, tif.overrun} !== 4'b0000) begin
            n_mis++; $display("FAIL reset_flags: got %b want 0000", {tif.busy, tif.expire, tif.irq, tif.overrun});
        end
        n_cmp++; if (tif.value !== 8'd0) begin
            n_mis++; $display("FAIL reset_value: got %0d want 0", tif.value);
        end
        n_cmp++; if (dut.state_q !== IDLE) begin
            n_mis++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
        end
        // tc already high when reset releases must still register as an edge.
        tc = 1'b1;
        step();
        reset = 1'b1;
        n_cmp++; if (dut.tick !== 1'b1) begin
            n_mis++; $display("FAIL reset_first_tick: got %b want 1", dut.tick);
        end
        tc = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        int s;
        do_start(8'd3, TT_ONESHOT);
        n_cmp++; if (tif.busy !== 1'b1 || tif.value !== 8'd3) begin
            n_mis++; $display("FAIL oneshot_load: got busy=%b value=%0d want busy=1 value=3", tif.busy, tif.value);
        end
        n_exp   = 0;
        pre_cnt = 4'hE;
        pre_en  = 1'b1;
        wait_value_change(40, s);
        n_cmp++; if (tif.value !== 8'd2) begin
            n_mis++; $display("FAIL oneshot_first_tick: got %0d want 2", tif.value);
        end
        wait_value_change(40, s);
        n_cmp++; if (tif.value !== 8'd1 || s !== 16) begin
            n_mis++; $display("FAIL oneshot_second_tick: got value=%0d gap=%0d want value=1 gap=16", tif.value, s);
        end
        wait_value_change(40, s);
        n_cmp++; if (tif.value !== 8'd0 || s !== 16) begin
            n_mis++; $display("FAIL oneshot_expiry_tick: got value=%0d gap=%0d want value=0 gap=16", tif.value, s);
        end
        n_cmp++; if ({tif.expire, tif.irq, tif.busy} !== 3'b110) begin
            n_mis++; $display("FAIL oneshot_expire_flags: got expire,irq,busy=%b want 110", {tif.expire, tif.irq, tif.busy});
        end
        n_cmp++; if (dut.state_q !== DONE) begin
            n_mis++; $display("FAIL oneshot_done_state: got %0d want %0d", dut.state_q, DONE);
        end
        step();
        if (tif.expire === 1'b1) n_exp++;
        pre_en = 1'b0;
        tc     = 1'b0;
        n_cmp++; if (tif.expire !== 1'b0 || n_exp !== 1) begin
            n_mis++; $display("FAIL oneshot_single_pulse: got expire=%b pulses=%0d want expire=0 pulses=1", tif.expire, n_exp);
        end
        tif.irq_ack = 1'b1;
        step();
        tif.irq_ack = 1'b0;
        n_cmp++; if ({tif.irq, tif.busy} !== 2'b00 || dut.state_q !== IDLE) begin
            n_mis++; $display("FAIL oneshot_ack: got irq,busy=%b state=%0d want 00 state=%0d", {tif.irq, tif.busy}, dut.state_q, IDLE);
        end
    endtask

    task automatic test_auto_overrun();
        logic [7:0] exp_val [4] = '{8'd1, 8'd2, 8'd1, 8'd2};
        logic [3:0] exp_flg [4] = '{4'b0000, 4'b0110, 4'b0010, 4'b0111};
        do_start(8'd2, TT_AUTO);
        n_cmp++; if (tif.value !== 8'd2 || tif.busy !== 1'b1) begin
            n_mis++; $display("FAIL auto_load: got value=%0d busy=%b want 2/1", tif.value, tif.busy);
        end
        // flags checked as {0, expire, irq, overrun}
        for (int i = 0; i < 4; i++) begin
            tick_once();
            n_cmp++; if (tif.value !== exp_val[i] || {1'b0, tif.expire, tif.irq, tif.overrun} !== exp_flg[i]) begin
                n_mis++; $display("FAIL auto_tick%0d: got value=%0d flags=%b want value=%0d flags=%b",
                                  i, tif.value, {1'b0, tif.expire, tif.irq, tif.overrun}, exp_val[i], exp_flg[i]);
            end
        end
        tif.irq_ack = 1'b1;
        step();
        tif.irq_ack = 1'b0;
        n_cmp++; if ({tif.irq, tif.overrun, tif.busy} !== 3'b001 || tif.value !== 8'd2) begin
            n_mis++; $display("FAIL auto_ack: got irq,overrun,busy=%b value=%0d want 001 value=2", {tif.irq, tif.overrun, tif.busy}, tif.value);
        end
    endtask

    task automatic test_ack_collision();
        tick_once();
        tick_once();
        tick_once();
        n_cmp++; if (tif.irq !== 1'b1 || tif.value !== 8'd1) begin
            n_mis++; $display("FAIL collide_setup: got irq=%b value=%0d want 1/1", tif.irq, tif.value);
        end
        tc = 1'b0;
        step();
        tc          = 1'b1;
        tif.irq_ack = 1'b1;
        step();
        tc          = 1'b0;
        tif.irq_ack = 1'b0;
        n_cmp++; if ({tif.expire, tif.irq, tif.overrun} !== 3'b110 || tif.value !== 8'd2) begin
            n_mis++; $display("FAIL collide_set_wins: got expire,irq,overrun=%b value=%0d want 110 value=2", {tif.expire, tif.irq, tif.overrun}, tif.value);
        end
        tif.irq_ack = 1'b1;
        tif.stop    = 1'b1;
        step();
        tif.irq_ack = 1'b0;
        tif.stop    = 1'b0;
        n_cmp++; if ({tif.irq, tif.busy} !== 2'b00 || tif.value !== 8'd0) begin
            n_mis++; $display("FAIL collide_cleanup: got irq,busy=%b value=%0d want 00 value=0", {tif.irq, tif.busy}, tif.value);
        end
    endtask

    task automatic test_stop_collision();
        do_start(8'd2, TT_ONESHOT);
        tick_once();
        n_cmp++; if (tif.value !== 8'd1) begin
            n_mis++; $display("FAIL stop_setup: got %0d want 1", tif.value);
        end
        tc = 1'b0;
        step();
        tc       = 1'b1;
        tif.stop = 1'b1;
        step();
        tc       = 1'b0;
        tif.stop = 1'b0;
        n_cmp++; if ({tif.expire, tif.irq, tif.busy} !== 3'b000 || tif.value !== 8'd0 || dut.state_q !== IDLE) begin
            n_mis++; $display("FAIL stop_collision: got expire,irq,busy=%b value=%0d state=%0d want 000 0 %0d",
                              {tif.expire, tif.irq, tif.busy}, tif.value, dut.state_q, IDLE);
        end
        step();
        n_cmp++; if ({tif.expire, tif.irq} !== 2'b00) begin
            n_mis++; $display("FAIL stop_no_late_expire: got expire,irq=%b want 00", {tif.expire, tif.irq});
        end
    endtask

    task automatic test_start_guard();
        do_start(8'd0, TT_ONESHOT);
        n_cmp++; if (tif.busy !== 1'b0 || tif.value !== 8'd0 || dut.state_q !== IDLE) begin
            n_mis++; $display("FAIL guard_idle: got busy=%b value=%0d want 0/0", tif.busy, tif.value);
        end
        do_start(8'd5, TT_ONESHOT);
        do_start(8'd0, TT_AUTO);
        n_cmp++; if (tif.busy !== 1'b1 || tif.value !== 8'd5) begin
            n_mis++; $display("FAIL guard_run: got busy=%b value=%0d want 1/5", tif.busy, tif.value);
        end
    endtask

    task automatic test_tick_qualify();
        tc = 1'b0;
        step();
        tc = 1'b1;
        step();
        n_cmp++; if (tif.value !== 8'd4) begin
            n_mis++; $display("FAIL qualify_first: got %0d want 4", tif.value);
        end
        step();
        step();
        tc = 1'b0;
        step();
        n_cmp++; if (tif.value !== 8'd4 || tif.busy !== 1'b1) begin
            n_mis++; $display("FAIL qualify_held: got value=%0d busy=%b want 4/1", tif.value, tif.busy);
        end
        tif.stop = 1'b1;
        step();
        tif.stop = 1'b0;
    endtask

    task automatic test_midrun_reset();
        do_start(8'd1, TT_AUTO);
        tick_once();
        n_cmp++; if ({tif.expire, tif.irq} !== 2'b11 || tif.value !== 8'd1) begin
            n_mis++; $display("FAIL midrun_p1_expire: got expire,irq=%b value=%0d want 11 value=1", {tif.expire, tif.irq}, tif.value);
        end
        do_start(8'd7, TT_AUTO);
        n_cmp++; if (tif.value !== 8'd7 || tif.busy !== 1'b1 || tif.irq !== 1'b1) begin
            n_mis++; $display("FAIL midrun_restart: got value=%0d busy=%b irq=%b want 7/1/1", tif.value, tif.busy, tif.irq);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_cmp++; if ({tif.busy, tif.expire, tif.irq, tif.overrun} !== 4'b0000 || tif.value !== 8'd0 || dut.state_q !== IDLE) begin
            n_mis++; $display("FAIL midrun_reset: got flags=%b value=%0d state=%0d want 0000 0 %0d",
                              {tif.busy, tif.expire, tif.irq, tif.overrun}, tif.value, dut.state_q, IDLE);
        end
        tick_once();
        tick_once();
        n_cmp++; if ({tif.busy, tif.irq} !== 2'b00 || tif.value !== 8'd0) begin
            n_mis++; $display("FAIL midrun_ticks_ignored: got busy,irq=%b value=%0d want 00 0", {tif.busy, tif.irq}, tif.value);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_mis   = 0;
        n_exp   = 0;
        pre_en  = 1'b0;
        pre_cnt = 4'h0;
        test_reset();
        test_oneshot();
        test_auto_overrun();
        test_ack_collision();
        test_stop_collision();
        test_start_guard();
        test_tick_qualify();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_tick_timer
